// File: rtl/rms_div_sched.sv
// Issue stage feeding div_pipe for RMSnorm: pairs each streamed x[i] with a latched rms
// divisor, collects quotients into a credit-protected FIFO. Optional: RMS_DIV_ZERO_CHK_EN.
module rms_div_sched #(
    parameter int DW         = 32,
    parameter int DIV_LAT    = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [DW-1:0]    rms,
    input  logic [DW-1:0]    x_data,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [DW-1:0]    div_a,
    output logic [DW-1:0]    div_b,
    output logic             div_ab_valid,
    input  logic [DW-1:0]    div_z,
    input  logic             div_z_valid,
    output logic [DW-1:0]    y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy,
    output logic             done,
    output logic             div_zero_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]    rms_q, rms_d;
    logic             done_zero_q, done_zero_d;
    logic             err_q, err_d;
    logic [DW-1:0]    fifo_mem_q [FIFO_DEPTH];

    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic          drain_done;
    logic          zero_hit;
    logic [DW-1:0] rms_latch;

`ifdef RMS_DIV_ZERO_CHK_EN
    // A zero or denormal FP32 divisor is replaced by the smallest normal, sign preserved.
    assign zero_hit  = (rms[30:23] == 8'h00);
    assign rms_latch = zero_hit ? {rms[DW-1], 31'h0080_0000} : rms;
`else
    assign zero_hit  = 1'b0;
    assign rms_latch = rms;
`endif

    // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
    assign credit_ok    = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CREDIT_LIMIT;
    assign x_ready      = (state_q == S_ISSUE) && credit_ok && (issued_q < len_q);
    assign issue        = x_valid && x_ready;
    assign div_ab_valid = issue;
    assign div_a        = issue ? x_data : '0;
    assign div_b        = rms_q;

    assign push    = div_z_valid && (inflight_q != '0);
    assign y_valid = (fifo_cnt_q != '0);
    assign pop     = y_valid && y_ready;
    assign y_data  = fifo_mem_q[rd_ptr_q];

    assign drain_done   = (state_q == S_DRAIN) && (retired_q == len_q);
    assign busy         = (state_q != S_IDLE);
    assign done         = drain_done || done_zero_q;
    assign div_zero_err = err_q;

    // NOTE: every signal written here gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        retired_d   = retired_q;
        rms_d       = rms_q;
        err_d       = err_q;
        done_zero_d = 1'b0;

        if (pop) begin
            retired_d = retired_q + LEN_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = vec_len;
                    rms_d     = rms_latch;
                    err_d     = err_q || zero_hit;
                    issued_d  = '0;
                    retired_d = '0;
                    if (vec_len != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    issued_d = issued_q + LEN_W'(1);
                    if ((issued_q + LEN_W'(1)) == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        unique case ({issue, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rms_q       <= '0;
            done_zero_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rms_q       <= rms_d;
            done_zero_q <= done_zero_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the FIFO storage is reset because y_data is the raw head and must read
    // zero out of reset; at this depth the reset cost is negligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= div_z;
        end
    end

    // div_pipe is fixed-latency; any result without an outstanding request is a protocol error.
    a_z_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        div_z_valid |-> (inflight_q != '0));

    a_z_latency: assert property (@(posedge clk) disable iff (!rst_n)
        div_z_valid |-> $past(div_ab_valid, DIV_LAT));

endmodule
